// File: rtl/logic_input.sv
// logic_input: synchronizes an async trigger and stretches each rising edge into a fixed-length pulse plus clear strobe.
module logic_input #(
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic tx,
  output logic tx_out,
  output logic clr
);
  typedef enum logic [1:0] {IDLE, ACTIVE, CLEAR} state_t;
  state_t state, next_state;
  logic [SYNC_STAGES-1:0] sync;
  logic hist;
  logic rise;
  logic [7:0] cnt, next_cnt;
  assign rise = sync[SYNC_STAGES-1] & ~hist;
  // Sync chain and history reset high so a TX held through reset release is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '1;
      hist <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      tx_out <= 1'b0;
      clr <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], tx};
      hist <= sync[SYNC_STAGES-1];
      state <= next_state;
      cnt <= next_cnt;
      tx_out <= next_state == ACTIVE;
      clr <= next_state == CLEAR;
    end
  end
  always_comb begin
    next_state = state;
    next_cnt = cnt;
    case (state)
      IDLE: if (rise) begin
        next_state = ACTIVE;
        next_cnt = 8'(PULSE_LEN - 1);
      end
      ACTIVE: if (cnt == 8'd0) next_state = CLEAR;
              else next_cnt = cnt - 8'd1;
      CLEAR: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end
endmodule

// File: tb/tb_logic_input.sv
// tb_logic_input: directed checks of pulse stretching, retrigger rejection and async reset behaviour.
module tb_logic_input;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx = 1'b0;
  logic tx_out, clr, tx_out1, clr1;
  int total = 0;
  int bad = 0;

  logic_input dut (.clk(clk), .rst(rst), .tx(tx), .tx_out(tx_out), .clr(clr));
  logic_input #(.SYNC_STAGES(2), .PULSE_LEN(1)) dut1 (.clk(clk), .rst(rst), .tx(tx), .tx_out(tx_out1), .clr(clr1));

  always #20 clk = ~clk;

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if (tx_out !== 1'b0 || clr !== 1'b0) begin
      bad++;
      $display("FAIL reset: tx_out=%b clr=%b expected 0 0", tx_out, clr);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (tx_out !== 1'b0 || clr !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: tx_out=%b clr=%b expected 0 0", tx_out, clr);
    end
  endtask

  // one-cycle TX pulse: tx_out on negedges 3..10 after drive, clr on 11
  task automatic test_basic(input int rep);
    repeat (12) @(negedge clk);
    tx = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      if (i == 1) tx = 1'b0;
      total++;
      if (tx_out !== (i >= 3 && i <= 10) || clr !== (i == 11)) begin
        bad++;
        $display("FAIL basic%0d cyc%0d: tx_out=%b clr=%b expected %b %b", rep, i, tx_out, clr, i >= 3 && i <= 10, i == 11);
      end
    end
  endtask

  task automatic test_held();
    repeat (12) @(negedge clk);
    tx = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      total++;
      if (tx_out !== (i >= 3 && i <= 10) || clr !== (i == 11)) begin
        bad++;
        $display("FAIL held cyc%0d: tx_out=%b clr=%b expected %b %b", i, tx_out, clr, i >= 3 && i <= 10, i == 11);
      end
    end
    tx = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      total++;
      if (tx_out !== 1'b0 || clr !== 1'b0) begin
        bad++;
        $display("FAIL held_fall cyc%0d: tx_out=%b clr=%b expected 0 0", i, tx_out, clr);
      end
    end
  endtask

  task automatic test_retrigger();
    repeat (12) @(negedge clk);
    tx = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      tx = (i == 6);
      total++;
      if (tx_out !== (i >= 3 && i <= 10) || clr !== (i == 11)) begin
        bad++;
        $display("FAIL retrigger cyc%0d: tx_out=%b clr=%b expected %b %b", i, tx_out, clr, i >= 3 && i <= 10, i == 11);
      end
    end
  endtask

  task automatic test_abort();
    repeat (12) @(negedge clk);
    tx = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) tx = 1'b0;
    end
    total++;
    if (tx_out !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre: tx_out=%b expected 1", tx_out);
    end
    #5 rst = 1'b1;
    #1;
    total++;
    if (tx_out !== 1'b0 || clr !== 1'b0) begin
      bad++;
      $display("FAIL abort_async: tx_out=%b clr=%b expected 0 0", tx_out, clr);
    end
    #9 rst = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      total++;
      if (tx_out !== 1'b0 || clr !== 1'b0) begin
        bad++;
        $display("FAIL abort_after cyc%0d: tx_out=%b clr=%b expected 0 0", i, tx_out, clr);
      end
    end
  endtask

  task automatic test_tx_through_reset();
    repeat (12) @(negedge clk);
    tx = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      total++;
      if (tx_out !== 1'b0 || clr !== 1'b0) begin
        bad++;
        $display("FAIL tx_high_release cyc%0d: tx_out=%b clr=%b expected 0 0", i, tx_out, clr);
      end
    end
    tx = 1'b0;
    repeat (2) @(negedge clk);
    tx = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      if (i == 1) tx = 1'b0;
      total++;
      if (tx_out !== (i >= 3 && i <= 10) || clr !== (i == 11)) begin
        bad++;
        $display("FAIL rearm cyc%0d: tx_out=%b clr=%b expected %b %b", i, tx_out, clr, i >= 3 && i <= 10, i == 11);
      end
    end
  endtask

  task automatic test_len1();
    repeat (12) @(negedge clk);
    tx = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) tx = 1'b0;
      total++;
      if (tx_out1 !== (i == 3) || clr1 !== (i == 4)) begin
        bad++;
        $display("FAIL len1 cyc%0d: tx_out=%b clr=%b expected %b %b", i, tx_out1, clr1, i == 3, i == 4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic(1);
    test_basic(2);
    test_held();
    test_retrigger();
    test_abort();
    test_tx_through_reset();
    test_len1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/logic_input.md
LOGIC_INPUT -- requirements
Module: logic_input

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of TX synchronizer flip-flops (legal 2..4).
REQ-002 Parameter PULSE_LEN, default 8, TX_OUT high duration in CLK cycles (legal 1..255).
REQ-003 CLK  input  1  single system clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 TX  input  1  asynchronous trigger request; a low-to-high transition requests one output pulse.
REQ-006 TX_OUT  output  1  registered, stretched, clock-aligned trigger pulse.
REQ-007 CLR  output  1  registered one-cycle clear strobe for downstream counters, issued when a pulse completes.
REQ-008 The design SHALL have one clock only; reset is asynchronous and active-high.

Function
REQ-009 TX SHALL pass through a SYNC_STAGES-deep flip-flop chain before any use; no logic SHALL read raw TX.
REQ-010 A rising edge SHALL be detected when the synchronized TX is 1 and the history register holds 0.
REQ-011 FSM states: IDLE, ACTIVE, CLEAR; encoding is free.
REQ-012 IDLE: TX_OUT=0, CLR=0; on a detected edge, go to ACTIVE and load the length counter with PULSE_LEN-1.
REQ-013 ACTIVE: TX_OUT=1; the counter decrements each cycle; when the counter is 0, go to CLEAR.
REQ-014 CLEAR: TX_OUT=0, CLR=1 for exactly one cycle, then go to IDLE.
REQ-015 TX_OUT SHALL be high for exactly PULSE_LEN consecutive cycles per accepted edge.
REQ-016 CLR SHALL assert in the cycle immediately after TX_OUT's last high cycle and never overlap TX_OUT.
REQ-017 Latency: with SYNC_STAGES=2, TX first sampled high at edge k gives TX_OUT high from edge k+2.
REQ-018 Edges detected in ACTIVE or CLEAR SHALL be discarded, not queued; retrigger needs a new edge in IDLE.
REQ-019 TX held high indefinitely SHALL produce exactly one pulse; a new pulse needs TX low for at least one sampled cycle.
REQ-020 TX pulses shorter than one CLK period may be missed; this is permitted.
REQ-021 The length counter width SHALL be 8 bits; no wrap-around occurs within legal PULSE_LEN.
REQ-022 With PULSE_LEN=1, ACTIVE SHALL last one cycle, then CLEAR.

Reset
REQ-023 RST=1 SHALL immediately force state to IDLE, TX_OUT=0, CLR=0, and the counter to 0, without waiting for CLK.
REQ-024 All synchronizer stages and the edge history register SHALL reset to 1, so TX high through reset release produces no pulse.
REQ-025 RST asserted mid-ACTIVE or mid-CLEAR SHALL abort the pulse; no CLR is issued for the aborted pulse.
REQ-026 After RST deasserts, the first accepted edge SHALL need a TX 0-to-1 transition seen after release.

Verification
REQ-027 CLK 40 ns period, TX high 40 ns every 540 ns -> each TX pulse yields TX_OUT high 8 cycles (320 ns) then CLR high 1 cycle; 1 pulse per TX period.
REQ-028 TX rises, sampled at edge k, held high 2 us -> TX_OUT high edges k+2..k+9, CLR at k+10, no further pulse until TX falls and rises again.
REQ-029 Second TX rising edge 3 cycles after TX_OUT rises -> ignored; TX_OUT total exactly 8 cycles, single CLR.
REQ-030 RST pulsed while TX_OUT high (cycle 4 of 8) -> TX_OUT and CLR drop to 0 asynchronously; no CLR after release.
REQ-031 TX=1 during and after RST release -> TX_OUT stays 0; then TX low 2 cycles and high -> normal 8-cycle pulse.
REQ-032 PULSE_LEN=1 build, single TX edge -> TX_OUT high 1 cycle, CLR high next cycle, then IDLE.
